// File: rtl/counter_checker.sv
// Checks that the eight counter bits arriving over the interconnect advance by one
// every clock (mod 256); locks onto the sequence and keeps sticky mismatch status.
module counter_checker #(
  parameter int unsigned SYNC_MATCHES = 4,
  parameter int unsigned LOSS_LIMIT   = 3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       CLEAR,
  input  logic       C0,
  input  logic       C1,
  input  logic       C2,
  input  logic       C3,
  input  logic       C4,
  input  logic       C5,
  input  logic       C6,
  input  logic       C7,
  output logic       LOCKED,
  output logic       MISMATCH,
  output logic       ERROR,
  output logic [7:0] ERR_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam logic [3:0] SYNC_N = 4'(SYNC_MATCHES);
  localparam logic [3:0] LOSS_N = 4'(LOSS_LIMIT);

  logic [7:0] value;
  assign value = {C7, C6, C5, C4, C3, C2, C1, C0};

  state_e     state_q, state_d;
  logic [7:0] cur_q, prev_q;
  logic [3:0] run_q, run_d;
  logic [3:0] miss_q, miss_d;
  logic       vld_q, vld_d;       // cur holds a sample taken while checking
  logic       primed_q, primed_d; // prev holds such a sample too
  logic       mm_q, mm_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  logic [7:0] prev_inc;
  logic       good;
  logic [3:0] run_inc, miss_inc;

  assign prev_inc = prev_q + 8'd1;
  assign good     = (cur_q == prev_inc);
  assign run_inc  = run_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;

  always_comb begin
    // NOTE: every _d gets its default before any branch, so no path can infer a latch.
    state_d  = state_q;
    run_d    = run_q;
    miss_d   = miss_q;
    vld_d    = vld_q;
    primed_d = primed_q;
    mm_d     = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        run_d    = 4'd0;
        miss_d   = 4'd0;
        vld_d    = 1'b0;
        primed_d = 1'b0;
        if (ENABLE) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        vld_d    = 1'b1;
        primed_d = vld_q;
        if (primed_q) begin
          if (!good) begin
            run_d = 4'd0;
          end else if (run_inc == SYNC_N) begin
            state_d = ST_LOCKED;
            run_d   = 4'd0;
          end else begin
            run_d = run_inc;
          end
        end
      end
      ST_LOCKED: begin
        vld_d    = 1'b1;
        primed_d = vld_q;
        if (primed_q) begin
          if (good) begin
            miss_d = 4'd0;
          end else begin
            mm_d  = 1'b1;
            err_d = 1'b1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            if (miss_inc == LOSS_N) begin
              state_d = ST_ACQUIRE;
              run_d   = 4'd0;
              miss_d  = 4'd0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping ENABLE discards whatever this cycle's comparison found.
    if (!ENABLE) begin
      state_d  = ST_IDLE;
      run_d    = 4'd0;
      miss_d   = 4'd0;
      vld_d    = 1'b0;
      primed_d = 1'b0;
      mm_d     = 1'b0;
      err_d    = err_q;
      cnt_d    = cnt_q;
    end

    // CLEAR beats a same-cycle mismatch for the status, but the pulse still goes out.
    if (CLEAR) begin
      err_d = 1'b0;
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      cur_q    <= 8'd0;
      prev_q   <= 8'd0;
      run_q    <= 4'd0;
      miss_q   <= 4'd0;
      vld_q    <= 1'b0;
      primed_q <= 1'b0;
      mm_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      cur_q    <= value;
      prev_q   <= cur_q;
      run_q    <= run_d;
      miss_q   <= miss_d;
      vld_q    <= vld_d;
      primed_q <= primed_d;
      mm_q     <= mm_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign LOCKED    = (state_q == ST_LOCKED);
  assign MISMATCH  = mm_q;
  assign ERROR     = err_q;
  assign ERR_COUNT = cnt_q;

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: stimulus queues each expected MISMATCH pulse,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_counter_checker;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ENABLE = 1'b0;
  logic       CLEAR = 1'b0;
  logic [7:0] cval = 8'd0;

  logic       LOCKED, MISMATCH, ERROR;
  logic [7:0] ERR_COUNT;
  logic       s_LOCKED, s_MISMATCH, s_ERROR;
  logic [7:0] s_ERR_COUNT;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] v;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       err;
    logic       lk;
  } exp_t;
  exp_t exp_q[$];

  counter_checker #(.SYNC_MATCHES(4), .LOSS_LIMIT(3)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .CLEAR(CLEAR),
    .C0(cval[0]), .C1(cval[1]), .C2(cval[2]), .C3(cval[3]),
    .C4(cval[4]), .C5(cval[5]), .C6(cval[6]), .C7(cval[7]),
    .LOCKED(LOCKED), .MISMATCH(MISMATCH), .ERROR(ERROR), .ERR_COUNT(ERR_COUNT)
  );

  // Same stimulus, but loss of lock effectively disabled for the saturation run.
  counter_checker #(.SYNC_MATCHES(4), .LOSS_LIMIT(15)) u_sat (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .CLEAR(CLEAR),
    .C0(cval[0]), .C1(cval[1]), .C2(cval[2]), .C3(cval[3]),
    .C4(cval[4]), .C5(cval[5]), .C6(cval[6]), .C7(cval[7]),
    .LOCKED(s_LOCKED), .MISMATCH(s_MISMATCH), .ERROR(s_ERROR), .ERR_COUNT(s_ERR_COUNT)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a negedge: present one sample, return at the next negedge.
  task automatic drive(input logic [7:0] d);
    cval = d;
    @(negedge CLK);
  endtask

  // The next drive() carries a sample that should be flagged two edges later.
  task automatic push_mm(input logic [7:0] cnt, input logic err, input logic lk);
    exp_t e;
    e.cyc = cyc + 2;
    e.cnt = cnt;
    e.err = err;
    e.lk  = lk;
    exp_q.push_back(e);
  endtask

  task automatic count_to(input logic [7:0] target);
    while (v != target) begin
      drive(v);
      v = v + 8'd1;
    end
  endtask

  task automatic wait_lock(input string name, input int exp_lat);
    int lat = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(v);
      v = v + 8'd1;
      if (LOCKED) begin
        lat = i;
        break;
      end
    end
    check({name, "_locked"}, 32'(LOCKED), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  // Monitor: every MISMATCH pulse must match the head of the queue.
  always @(negedge CLK) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("mm_missing", 32'(cyc), 32'(exp_q[0].cyc));
      void'(exp_q.pop_front());
    end
    if (MISMATCH) begin
      if (exp_q.size() == 0) begin
        check("mm_unexpected", 32'(MISMATCH), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mm_cycle", 32'(cyc), 32'(e.cyc));
        check("mm_err_count", 32'(ERR_COUNT), 32'(e.cnt));
        check("mm_error", 32'(ERROR), 32'(e.err));
        check("mm_locked", 32'(LOCKED), 32'(e.lk));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    @(negedge CLK);

    // Reset with random counter bits
    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    for (int i = 0; i < 2; i++) drive(8'($urandom));
    check("rst_locked", 32'(LOCKED), 32'd0);
    check("rst_mismatch", 32'(MISMATCH), 32'd0);
    check("rst_error", 32'(ERROR), 32'd0);
    check("rst_err_count", 32'(ERR_COUNT), 32'd0);

    // Release and lock onto 0x10, 0x11, ...
    RESET_N = 1'b1;
    ENABLE  = 1'b1;
    v = 8'h10;
    wait_lock("first_lock", 7);
    check("first_lock_err_count", 32'(ERR_COUNT), 32'd0);

    // Wrap through 0xFD..0x02
    count_to(8'h03);
    check("wrap_error", 32'(ERROR), 32'd0);
    check("wrap_err_count", 32'(ERR_COUNT), 32'd0);
    check("wrap_locked", 32'(LOCKED), 32'd1);

    // Single fault: 0x40 0x41 0x43 0x44
    count_to(8'h40);
    drive(8'h40);
    drive(8'h41);
    push_mm(8'd1, 1'b1, 1'b1);
    drive(8'h43);
    drive(8'h44);
    v = 8'h45;
    check("fault_err_count", 32'(ERR_COUNT), 32'd1);
    check("fault_error", 32'(ERROR), 32'd1);
    check("fault_locked", 32'(LOCKED), 32'd1);
    drive(v);
    v = v + 8'd1;

    // CLEAR alone leaves the state machine locked
    CLEAR = 1'b1;
    drive(v);
    v = v + 8'd1;
    CLEAR = 1'b0;
    check("clear_err_count", 32'(ERR_COUNT), 32'd0);
    check("clear_error", 32'(ERROR), 32'd0);
    check("clear_locked", 32'(LOCKED), 32'd1);

    // Loss of lock: 0x1F 0x20 then three stuck 0x20 samples
    count_to(8'h20);
    drive(8'h20);
    push_mm(8'd1, 1'b1, 1'b1);
    drive(8'h20);
    push_mm(8'd2, 1'b1, 1'b1);
    drive(8'h20);
    push_mm(8'd3, 1'b1, 1'b0);
    drive(8'h20);
    v = 8'h21;
    wait_lock("relock", 5);
    check("relock_error", 32'(ERROR), 32'd1);
    check("relock_err_count", 32'(ERR_COUNT), 32'd3);
    check("sat_inst_stays_locked", 32'(s_LOCKED), 32'd1);

    // Mid-run disable for one cycle
    ENABLE = 1'b0;
    drive(v);
    v = v + 8'd1;
    check("dis_locked", 32'(LOCKED), 32'd0);
    check("dis_err_count", 32'(ERR_COUNT), 32'd3);
    check("dis_error", 32'(ERROR), 32'd1);
    ENABLE = 1'b1;
    wait_lock("reenable", 7);

    // Saturation: 300 alternating bad/good samples
    CLEAR = 1'b1;
    drive(v);
    v = v + 8'd1;
    CLEAR = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      push_mm((k > 255) ? 8'd255 : 8'(k), 1'b1, 1'b1);
      drive(v + 8'd1);
      drive(v + 8'd2);
      v = v + 8'd3;
    end
    check("sat_err_count", 32'(s_ERR_COUNT), 32'd255);
    check("sat_error", 32'(s_ERROR), 32'd1);
    check("sat_locked", 32'(s_LOCKED), 32'd1);
    check("sat_main_err_count", 32'(ERR_COUNT), 32'd255);

    // CLEAR coincident with a mismatch
    push_mm(8'd0, 1'b0, 1'b1);
    drive(v + 8'd1);
    CLEAR = 1'b1;
    drive(v + 8'd2);
    CLEAR = 1'b0;
    v = v + 8'd3;
    check("clr_mm_sat_err_count", 32'(s_ERR_COUNT), 32'd0);
    check("clr_mm_sat_error", 32'(s_ERROR), 32'd0);
    check("clr_mm_sat_pulse", 32'(s_MISMATCH), 32'd1);

    // One more fault, then a one-cycle reset while locked
    push_mm(8'd1, 1'b1, 1'b1);
    drive(v + 8'd1);
    drive(v + 8'd2);
    v = v + 8'd3;
    check("pre_rst_error", 32'(ERROR), 32'd1);
    RESET_N = 1'b0;
    drive(v);
    v = v + 8'd1;
    check("midrst_locked", 32'(LOCKED), 32'd0);
    check("midrst_mismatch", 32'(MISMATCH), 32'd0);
    check("midrst_error", 32'(ERROR), 32'd0);
    check("midrst_err_count", 32'(ERR_COUNT), 32'd0);
    RESET_N = 1'b1;
    drive(v);
    drive(v + 8'd1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
# counter_checker

Synchronous checker downstream of the 8-bit free-running counter stage. It samples the eight counter bits C0..C7 after they cross the interconnect under test and verifies that each sample equals the previous sample plus one, modulo 256. It locks onto the sequence, counts mismatches, and reports sticky error status. It gives a pass/fail verdict for the interconnect path between the counter and this block.

## Interface
- SYNC_MATCHES, default 4: consecutive correct increments needed to enter LOCKED (legal range 1..15).
- LOSS_LIMIT, default 3: consecutive mismatches in LOCKED that force a return to ACQUIRE (legal range 1..15).
- CLK  input  1  single clock; the counter bits are driven from the same clock domain.
- RESET_N  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- ENABLE  input  1  1 = checking active; 0 = return to IDLE.
- CLEAR  input  1  synchronous clear of ERR_COUNT and ERROR; has no effect on the state machine.
- C0..C7  input  1 each  counter bits, C0 = LSB; assembled internally as value[7:0].
- LOCKED  output  1  high while the state is LOCKED.
- MISMATCH  output  1  one-cycle pulse for each mismatch detected in LOCKED.
- ERROR  output  1  sticky; set by the first mismatch in LOCKED.
- ERR_COUNT  output  8  count of mismatches in LOCKED, saturating at 255.

## Operation
Sampling:
- Every rising edge of CLK registers value into cur.
- In the same edge, the old cur moves into prev.
- primed is set once prev holds a valid sample. It is cleared in IDLE and in reset.

Check:
- good = (cur == prev + 8'd1), computed with 8-bit wrap.
- The transition 255 -> 0 is good.
- The check is evaluated only when primed = 1.

States:
- IDLE: entered on reset or when ENABLE = 0.
  - run, miss and primed are cleared.
  - Moves to ACQUIRE on the first edge where ENABLE = 1.
- ACQUIRE:
  - On a good comparison: run increments. When run reaches SYNC_MATCHES, move to LOCKED and set run to 0.
  - On a bad comparison: run is set to 0. The mismatch is not counted, MISMATCH does not pulse, and ERROR is not set.
- LOCKED:
  - On a good comparison: miss is set to 0.
  - On a bad comparison:
    - MISMATCH pulses.
    - ERROR is set.
    - ERR_COUNT increments, saturating at 255.
    - miss increments. When miss reaches LOSS_LIMIT, move to ACQUIRE with run = 0 and miss = 0.
- ENABLE = 0 in any state moves to IDLE on the next edge. ERROR and ERR_COUNT are retained.

Priority and simultaneous events:
- RESET_N low overrides everything.
- CLEAR and a mismatch in the same cycle: CLEAR wins. ERR_COUNT = 0 and ERROR = 0 for that cycle. MISMATCH still pulses.
- ENABLE = 0 in the same cycle as a mismatch: the mismatch is discarded and the state moves to IDLE.

Reset values (RESET_N low at a rising edge):
- State = IDLE; cur, prev, run, miss and primed = 0.
- LOCKED = 0, MISMATCH = 0, ERROR = 0, ERR_COUNT = 0.
- A reset in the middle of operation behaves identically and discards all history.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- A sample presented before edge n is captured into cur at edge n.
- The comparison of that sample against its predecessor updates the state and outputs at edge n+1.
- MISMATCH is therefore high for exactly the cycle following edge n+1.
- Lock latency after ENABLE rises, with a correct sequence and SYNC_MATCHES = 4:
  - The first good comparison is available after 2 samples.
  - LOCKED rises at edge 1 + (SYNC_MATCHES + 1) + 1 = edge 7 counted from the first enabled edge.
  - The bench shall check LOCKED = 1 no later than 8 cycles after ENABLE rises.
- Throughput is one sample per cycle, with no stalls.

## Test plan
- **Reset:** hold RESET_N = 0 for 2 cycles with random C inputs.
  - All outputs 0 and state IDLE.
  - Release, apply ENABLE = 1 and a counting sequence 0x10, 0x11, ...
  - LOCKED = 1 within 8 cycles; ERR_COUNT stays 0.
- **Wrap:** lock, then drive 0xFD, 0xFE, 0xFF, 0x00, 0x01.
  - MISMATCH never pulses; ERROR = 0.
- **Single fault:** lock, then drive 0x40, 0x41, 0x43, 0x44.
  - Faulty sample is 0x43; MISMATCH pulses for one cycle 2 edges after it.
  - ERR_COUNT = 1 and ERROR = 1.
  - LOCKED stays 1, since there is one miss, which is below LOSS_LIMIT = 3.
- **Loss of lock:** lock, then drive 3 consecutive non-incrementing samples (0x20, 0x20, 0x20, 0x20).
  - ERR_COUNT = 3 and LOCKED falls.
  - Resume counting from 0x21: relock after 4 good increments, ERROR stays 1.
- **Saturation and CLEAR:** in LOCKED with LOSS_LIMIT forced large (15), inject alternating bad/good samples until 300 mismatches have occurred.
  - ERR_COUNT = 255 and does not wrap.
  - Pulse CLEAR coincident with a mismatch: ERR_COUNT = 0, ERROR = 0, and MISMATCH still pulses.
- **Mid-run disable and reset:** lock, drop ENABLE for 1 cycle.
  - LOCKED = 0 next cycle and ERR_COUNT is retained.
  - Re-enable: relock.
  - Assert RESET_N = 0 for 1 cycle while locked: all outputs return to 0.
